// File: rtl/mac_int_stream.sv
// Streaming signed multiply-accumulate: one dot product per in_last-delimited vector.
// Optional MAC_SATURATE_EN: clamp the accumulator on overflow instead of wrapping.
module mac_int_stream #(
  parameter int IN_W    = 8,
  parameter int ACC_W   = 20,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] y,
  output logic [CNT_W-1:0]        count,
  output logic                    overflow,
  output logic                    len_err
);

  typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  p_q, p_d;
  logic                     pv_q, pv_d;
  logic                     plen_q, plen_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic signed [ACC_W-1:0]  y_q, y_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic                     len_err_q, len_err_d;
`ifdef MAC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic                     sat_q, sat_d;
  logic                     sat_neg_q, sat_neg_d;
`endif

  logic                     accept;
  logic signed [2*IN_W-1:0] prod;
  logic [CNT_W-1:0]         beats_seen;
  logic                     len_hit;
  logic                     last_eff;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  sum_fin;
  logic                     add_ovf;
  logic                     ovf_next;

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    pv_d       = 1'b0;
    plen_d     = plen_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    y_d        = y_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    len_err_d  = len_err_q;
`ifdef MAC_SATURATE_EN
    sat_d      = sat_q;
    sat_neg_d  = sat_neg_q;
`endif

    accept     = in_valid && (state_q == ACCUM);
    prod       = (2*IN_W)'(a) * (2*IN_W)'(b);
    // Beats accepted so far include the one still waiting in stage 1.
    beats_seen = cnt_q + CNT_W'(pv_q);
    len_hit    = (beats_seen == CNT_W'(MAX_LEN - 1));
    last_eff   = in_last | len_hit;

    acc_base   = (cnt_q == '0) ? '0 : acc_q;
    sum        = acc_base + p_q;
    add_ovf    = (acc_base[ACC_W-1] == p_q[ACC_W-1]) && (sum[ACC_W-1] != acc_base[ACC_W-1]);
    ovf_next   = ovf_q | add_ovf;
    sum_fin    = sum;
`ifdef MAC_SATURATE_EN
    if (sat_q) begin
      sum_fin = sat_neg_q ? ACC_MIN : ACC_MAX;
    end else if (add_ovf) begin
      sum_fin = p_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
`endif

    if (accept) begin
      p_d    = ACC_W'(prod);
      pv_d   = 1'b1;
      plen_d = len_hit & ~in_last;
    end

    if (pv_q) begin
      acc_d = sum_fin;
      cnt_d = cnt_q + 1'b1;
      ovf_d = ovf_next;
`ifdef MAC_SATURATE_EN
      if (!sat_q && add_ovf) begin
        sat_d     = 1'b1;
        sat_neg_d = p_q[ACC_W-1];
      end
`endif
    end

    case (state_q)
      ACCUM: if (accept && last_eff) state_d = FLUSH;
      FLUSH: begin
        // Capture the final sum directly so the result lands with the state change.
        state_d    = HOLD;
        y_d        = sum_fin;
        count_d    = cnt_q + 1'b1;
        overflow_d = ovf_next;
        len_err_d  = plen_q;
        acc_d      = '0;
        cnt_d      = '0;
        ovf_d      = 1'b0;
`ifdef MAC_SATURATE_EN
        sat_d      = 1'b0;
        sat_neg_d  = 1'b0;
`endif
      end
      HOLD:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase

    if (clear) begin
      state_d = ACCUM;
      pv_d    = 1'b0;
      plen_d  = 1'b0;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
`ifdef MAC_SATURATE_EN
      sat_d     = 1'b0;
      sat_neg_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ACCUM;
      p_q        <= '0;
      pv_q       <= 1'b0;
      plen_q     <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      y_q        <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      len_err_q  <= 1'b0;
`ifdef MAC_SATURATE_EN
      sat_q      <= 1'b0;
      sat_neg_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      pv_q       <= pv_d;
      plen_q     <= plen_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      y_q        <= y_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      len_err_q  <= len_err_d;
`ifdef MAC_SATURATE_EN
      sat_q      <= sat_d;
      sat_neg_q  <= sat_neg_d;
`endif
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign y         = y_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign len_err   = len_err_q;

endmodule
